// File: rtl/muldiv_if.sv
// Request/response bundle for the iterative multiply/divide unit.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hold;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    modport master (
        output start, op, a, b, hold, flush,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b, hold, flush,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative 32x32 multiply / restoring divide, 32 steps per operation.
// Divide hardware is present only when MULDIV_DIV_EN is defined.
module muldiv_unit (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] opd_q, opd_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dbz_q, dbz_d;
`ifdef MULDIV_DIV_EN
    logic        neg_rem_q, neg_rem_d;
    logic        bzero_q, bzero_d;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
`endif

    logic [32:0] mul_sum;
    logic [31:0] rem_step, quo_step;
    logic [63:0] prod_abs, prod_fin;
    logic [31:0] res_hi, res_lo;
    logic        res_dbz;
    logic        sgn;
    logic [31:0] a_abs, b_abs;

    // Multiply keeps {rem, quo} as the shifting product with the multiplier in quo;
    // divide shifts the dividend out of quo while quotient bits shift in.
    always_comb begin
        mul_sum = {1'b0, rem_q} + {1'b0, (quo_q[0] ? opd_q : 32'd0)};
        rem_step = mul_sum[32:1];
        quo_step = {mul_sum[0], quo_q[31:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {rem_q, quo_q[31]};
        div_diff  = div_shift - {1'b0, opd_q};
        div_ge    = div_shift >= {1'b0, opd_q};
        if (is_div_q) begin
            rem_step = div_ge ? div_diff[31:0] : div_shift[31:0];
            quo_step = {quo_q[30:0], div_ge};
        end
`else
        if (is_div_q) begin
            rem_step = rem_q;
            quo_step = quo_q;
        end
`endif
    end

    always_comb begin
        prod_abs = {rem_step, quo_step};
        prod_fin = neg_res_q ? (64'd0 - prod_abs) : prod_abs;
        res_hi   = prod_fin[63:32];
        res_lo   = prod_fin[31:0];
        res_dbz  = 1'b0;
        if (is_div_q) begin
`ifdef MULDIV_DIV_EN
            // With b==0 the remainder is |a|; restoring its sign yields the original a.
            res_hi  = neg_rem_q ? (32'd0 - rem_step) : rem_step;
            res_lo  = bzero_q ? 32'hFFFF_FFFF : (neg_res_q ? (32'd0 - quo_step) : quo_step);
            res_dbz = bzero_q;
`else
            res_hi  = 32'd0;
            res_lo  = 32'd0;
`endif
        end
    end

    always_comb begin
        sgn   = ~bus.op[0];
        a_abs = (sgn && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
        b_abs = (sgn && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        opd_d     = opd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
`ifdef MULDIV_DIV_EN
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
`endif

        if (bus.flush) begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
        end else if (!bus.hold) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (bus.start) begin
                        state_d   = S_CALC;
                        cnt_d     = 6'd0;
                        is_div_d  = bus.op[1];
                        neg_res_d = sgn & (bus.a[31] ^ bus.b[31]);
                        rem_d     = 32'd0;
                        quo_d     = bus.op[1] ? a_abs : b_abs;
                        opd_d     = bus.op[1] ? b_abs : a_abs;
                        dbz_d     = 1'b0;
`ifdef MULDIV_DIV_EN
                        neg_rem_d = sgn & bus.a[31];
                        bzero_d   = bus.op[1] & (bus.b == 32'd0);
`endif
                    end
                end
                S_CALC: begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = S_DONE;
                        hi_d    = res_hi;
                        lo_d    = res_lo;
                        dbz_d   = res_dbz;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            opd_q     <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            dbz_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            opd_q     <= opd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
`ifdef MULDIV_DIV_EN
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
`endif
        end
    end

    assign bus.busy        = (state_q == S_CALC);
    assign bus.done        = (state_q == S_DONE);
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = (state_q == S_DONE) & dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic clk;
    logic reset;
    muldiv_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;
    int          n_tests;
    int          n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h required %08h", name, act, req);
        end
    endtask

    // Reference: what the unit must return, from plain integer arithmetic.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sa, sb;
        dbz = 1'b0;
        hi  = 32'd0;
        lo  = 32'd0;
        case (op)
            2'b00: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                hi = sp[63:32];
                lo = sp[31:0];
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) begin
                    lo  = 32'hFFFF_FFFF;
                    hi  = a;
                    dbz = 1'b1;
                end else if (op == 2'b11) begin
                    lo = a / b;
                    hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'd0;
                end else begin
                    sa = a;
                    sb = b;
                    lo = sa / sb;
                    hi = sa % sb;
                end
`endif
            end
        endcase
    endtask

    // Compare process: on every completion check against the scoreboard;
    // otherwise hi/lo must keep the last completed result.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_hi", bus.hi, e.hi);
                    check("result_lo", bus.lo, e.lo);
                    check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
                    $display("[TB] op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dbz=%0d",
                             e.op, e.a, e.b, bus.hi, bus.lo, bus.div_by_zero);
                    cur_hi = e.hi;
                    cur_lo = e.lo;
                end
            end else begin
                check("hold_hi", bus.hi, cur_hi);
                check("hold_lo", bus.lo, cur_lo);
                check("dbz_idle", {31'd0, bus.div_by_zero}, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.op = op;
        e.a  = a;
        e.b  = b;
        model(op, a, b, e.hi, e.lo, e.dbz);
        exp_q.push_back(e);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    // Counts edges from the accepting edge until done is seen.
    task automatic wait_done(input int exp_lat, input int hold_at, input int hold_len,
                             input int junk_at, input string name);
        int n;
        step();
        bus.start = 1'b0;
        n = 0;
        while (1) begin
            if (bus.done) break;
            check({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
            if (n > exp_lat + 8) begin
                check({name, "_timeout"}, 32'd1, 32'd0);
                break;
            end
            bus.hold  = (n >= hold_at) && (n < hold_at + hold_len);
            bus.start = (n == junk_at);
            if (bus.start) begin
                bus.op = 2'($urandom_range(0, 3));
                bus.a  = $urandom;
                bus.b  = $urandom;
            end
            step();
            n++;
        end
        bus.hold  = 1'b0;
        bus.start = 1'b0;
        check({name, "_latency"}, n, exp_lat);
        check({name, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'd1;
            4: v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] mh, ml;
        logic        md;
        n_tests = 0;
        n_fail  = 0;
        cur_hi  = 32'd0;
        cur_lo  = 32'd0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.hold  = 1'b0;
        bus.flush = 1'b0;

        // Pin the model with hand-computed results.
        model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mh, ml, md);
        check("pin_multu_hi", mh, 32'hFFFF_FFFE);
        check("pin_multu_lo", ml, 32'h0000_0001);
        model(2'b00, 32'hFFFF_FFFD, 32'd5, mh, ml, md);
        check("pin_mult_hi", mh, 32'hFFFF_FFFF);
        check("pin_mult_lo", ml, 32'hFFFF_FFF1);
`ifdef MULDIV_DIV_EN
        model(2'b10, 32'hFFFF_FFF9, 32'd2, mh, ml, md);
        check("pin_div_lo", ml, 32'hFFFF_FFFD);
        check("pin_div_hi", mh, 32'hFFFF_FFFF);
        model(2'b11, 32'h64, 32'd0, mh, ml, md);
        check("pin_dbz_lo", ml, 32'hFFFF_FFFF);
        check("pin_dbz_hi", mh, 32'h64);
        check("pin_dbz_flag", {31'd0, md}, 32'd1);
        model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, mh, ml, md);
        check("pin_ovf_lo", ml, 32'h8000_0000);
        check("pin_ovf_hi", mh, 32'd0);
`else
        model(2'b10, 32'hFFFF_FFF9, 32'd2, mh, ml, md);
        check("pin_nodiv_lo", ml, 32'd0);
        check("pin_nodiv_hi", mh, 32'd0);
`endif

        #12;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        reset = 1'b0;
        step();

        // Directed corner cases (each back-to-back with the previous one).
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(32, -1, 0, -1, "multu_max");
        issue(2'b00, 32'hFFFF_FFFD, 32'd5);         wait_done(32, -1, 0, -1, "mult_neg");
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);         wait_done(32, -1, 0, -1, "div_neg");
        issue(2'b11, 32'h64, 32'd0);                wait_done(32, -1, 0, -1, "divu_zero");
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(32, -1, 0, -1, "div_ovf");
        issue(2'b10, 32'hFFFF_FF9C, 32'd0);         wait_done(32, -1, 0, -1, "div_neg_zero");

        // Hold for 5 cycles mid-CALC plus stray starts, which must be ignored.
        step();
        issue(2'b00, 32'h1234_5678, 32'h8765_4321); wait_done(37, 6, 5, 3, "hold5");
        issue(2'b11, 32'hDEAD_BEEF, 32'd7);         wait_done(37, 10, 5, 8, "hold5_div");

        // Flush after 10 steps: busy drops next cycle and no done ever appears.
        step();
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'hCAFE_F00D;
        bus.b     = 32'h0BAD_BEEF;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_busy", {31'd0, bus.busy}, 32'd0);
        check("flush_done", {31'd0, bus.done}, 32'd0);
        repeat (40) step();

        // Randomized operations, mostly back-to-back, some with idle gaps.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) step();
            issue(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
            wait_done(32, -1, 0, -1, "rand");
        end

        // Asynchronous reset mid-CALC clears outputs before the next edge.
        issue(2'b01, 32'hFFFF_FFFF, 32'h3);
        step();
        bus.start = 1'b0;
        repeat (5) step();
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_done", {31'd0, bus.done}, 32'd0);
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        exp_q.delete();
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        step();
        issue(2'b00, 32'h7FFF_FFFF, 32'h8000_0000); wait_done(32, -1, 0, -1, "after_rst");
        step();
        step();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
